// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared types and constants for the UART TX word arbiter.
//   uart_arb_state_t : arbiter FSM states
//   LEN_1B..LEN_4B   : req_len encodings (byte count minus one)
//   ACK_TO_DEFAULT   : default cycles to wait for tx_busy after tx_start
//   byte_sel()       : little-endian byte extraction from a 32-bit word
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } uart_arb_state_t;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  localparam int ACK_TO_DEFAULT = 16;

  // The byte index uses the same encoding as the length field, so the
  // LEN_* constants double as byte positions: LEN_1B selects byte 0.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      LEN_1B:  b = word[7:0];
      LEN_2B:  b = word[15:8];
      LEN_3B:  b = word[23:16];
      LEN_4B:  b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// uart_arb_rr_pick
// Combinational winner selection for the UART TX arbiter.
//   req     in  NREQ : request levels
//   last    in  IDXW : index of the previous owner (round-robin pointer)
//   gnt_oh  out NREQ : one-hot winner (all zero when no request)
//   gnt_idx out IDXW : binary index of the winner
//   gnt_vld out 1    : at least one request is present
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, last ignored); default is round-robin starting at last+1.
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld
);

`ifdef UART_ARB_FIXED_PRIO_EN

  logic unused_last_s;
  assign unused_last_s = ^last;

  // Fixed priority: scan from the top down so the lowest requester is the last to overwrite.
  always_comb begin
    gnt_oh  = {NREQ{1'b0}};
    gnt_idx = {IDXW{1'b0}};
    gnt_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_oh  = NREQ'(1'b1) << i;
        gnt_idx = IDXW'(i);
        gnt_vld = 1'b1;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

`else

  logic [IDXW-1:0] cand_s;

  // Round-robin: visit last+1, last+2, ... and wrap so the previous owner is checked last.
  always_comb begin
    gnt_oh  = {NREQ{1'b0}};
    gnt_idx = {IDXW{1'b0}};
    gnt_vld = 1'b0;
    cand_s  = {IDXW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = IDXW'((int'(last) + i) % NREQ);
      if (!gnt_vld && req[cand_s]) begin
        gnt_oh  = NREQ'(1'b1) << cand_s;
        gnt_idx = cand_s;
        gnt_vld = 1'b1;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

`endif

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one UART transmitter between NREQ word-oriented requesters. A
// granted word (1..4 bytes) is sent little-endian through the UART's
// tx_start/tx_busy handshake before the next requester is considered.
//   clk      in  1       : system clock
//   Rst      in  1       : synchronous active-high reset
//   req      in  NREQ    : request levels, held until gnt
//   req_word in  32*NREQ : word of requester i at [32*i +: 32]
//   req_len  in  2*NREQ  : byte count minus one at [2*i +: 2]
//   gnt      out NREQ    : one-hot pulse, word captured
//   done     out NREQ    : one-hot pulse, last byte of the word finished
//   tx_data  out 8       : byte to transmit
//   tx_start out 1       : one-cycle start pulse to the UART
//   tx_busy  in  1       : UART busy
//   arb_busy out 1       : arbiter not idle
// Build option: UART_ARB_FIXED_PRIO_EN selects fixed-priority arbitration
// (handled inside uart_arb_rr_pick).
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ACK_TO = ACK_TO_DEFAULT
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_word,
  input  logic [2*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              arb_busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(ACK_TO + 1);

  uart_arb_state_t state_r, state_nxt_s;
  logic [31:0]     word_r, word_nxt_s;
  logic [1:0]      len_r, len_nxt_s;
  logic [1:0]      idx_r, idx_nxt_s;
  logic [IDXW-1:0] owner_r, owner_nxt_s;
  logic [IDXW-1:0] last_r, last_nxt_s;
  logic [CNTW-1:0] cnt_r, cnt_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [NREQ-1:0] done_r, done_nxt_s;
  logic [7:0]      tx_data_r, tx_data_nxt_s;
  logic            tx_start_r, tx_start_nxt_s;
  logic            arb_busy_r;

  logic [NREQ-1:0] pick_oh_s;
  logic [IDXW-1:0] pick_idx_s;
  logic            pick_vld_s;
  logic [31:0]     sel_word_s;
  logic [1:0]      sel_len_s;

  uart_arb_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req     (req),
    .last    (last_r),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .gnt_vld (pick_vld_s)
  );

  // One-hot AND-OR mux of the winning requester's word and length.
  always_comb begin
    sel_word_s = 32'h0000_0000;
    sel_len_s  = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_word_s = sel_word_s | ({32{pick_oh_s[i]}} & req_word[32*i +: 32]);
      sel_len_s  = sel_len_s  | ({2{pick_oh_s[i]}}  & req_len[2*i +: 2]);
    end
  end

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    state_nxt_s    = state_r;
    word_nxt_s     = word_r;
    len_nxt_s      = len_r;
    idx_nxt_s      = idx_r;
    owner_nxt_s    = owner_r;
    last_nxt_s     = last_r;
    cnt_nxt_s      = cnt_r;
    gnt_nxt_s      = {NREQ{1'b0}};
    done_nxt_s     = {NREQ{1'b0}};
    tx_data_nxt_s  = tx_data_r;
    tx_start_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          word_nxt_s  = sel_word_s;
          len_nxt_s   = sel_len_s;
          owner_nxt_s = pick_idx_s;
          idx_nxt_s   = 2'd0;
          gnt_nxt_s   = pick_oh_s;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_nxt_s  = byte_sel(word_r, idx_r);
          tx_start_nxt_s = 1'b1;
          cnt_nxt_s      = {CNTW{1'b0}};
          state_nxt_s    = ST_WAIT_ACK;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        // The start cycle itself counts as the first waited cycle, so the
        // byte is re-issued after ACK_TO cycles without a busy response.
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r == CNTW'(ACK_TO - 1)) begin
          state_nxt_s = ST_SEND;
        end else begin
          cnt_nxt_s = cnt_r + CNTW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_r == len_r) begin
            done_nxt_s  = NREQ'(1'b1) << owner_r;
            last_nxt_s  = owner_r;
            state_nxt_s = ST_IDLE;
          end else begin
            idx_nxt_s   = idx_r + 2'd1;
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any word in progress.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r    <= ST_IDLE;
      word_r     <= 32'h0000_0000;
      len_r      <= LEN_1B;
      idx_r      <= 2'd0;
      owner_r    <= {IDXW{1'b0}};
      last_r     <= IDXW'(NREQ - 1);
      cnt_r      <= {CNTW{1'b0}};
      gnt_r      <= {NREQ{1'b0}};
      done_r     <= {NREQ{1'b0}};
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      arb_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      word_r     <= word_nxt_s;
      len_r      <= len_nxt_s;
      idx_r      <= idx_nxt_s;
      owner_r    <= owner_nxt_s;
      last_r     <= last_nxt_s;
      cnt_r      <= cnt_nxt_s;
      gnt_r      <= gnt_nxt_s;
      done_r     <= done_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_start_r <= tx_start_nxt_s;
      arb_busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign gnt      = gnt_r;
  assign done     = done_r;
  assign tx_data  = tx_data_r;
  assign tx_start = tx_start_r;
  assign arb_busy = arb_busy_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Directed bench for uart_tx_arb with a small UART model that goes busy for
// BUSY_LEN cycles after each accepted tx_start (one chosen start can be
// ignored to provoke the ack timeout).
module tb_uart_tx_arb;

  localparam int NREQ     = 2;
  localparam int ACK_TO   = 16;
  localparam int BUSY_LEN = 10;

  logic              clk = 1'b0;
  logic              Rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] req_word = '0;
  logic [2*NREQ-1:0] req_len = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              arb_busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .ACK_TO(ACK_TO)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .req      (req),
    .req_word (req_word),
    .req_len  (req_len),
    .gnt      (gnt),
    .done     (done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .arb_busy (arb_busy)
  );

  // UART model: busy from the cycle after an accepted start for BUSY_LEN cycles.
  int busy_cnt  = 0;
  int start_cnt = 0;
  int skip_idx  = -1;
  always @(posedge clk) begin
    if (tx_start) begin
      busy_cnt  <= (start_cnt == skip_idx) ? 0 : BUSY_LEN;
      start_cnt <= start_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = (busy_cnt != 0);

  // Monitor sampled mid-cycle.
  int         cyc = 0;
  logic [7:0] byte_q[$];
  int         start_q[$];
  int         gnt_cnt[NREQ]  = '{default: 0};
  int         done_cnt[NREQ] = '{default: 0};
  int         last_done_cyc = 0;
  int         overlap_cnt = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      byte_q.push_back(tx_data);
      start_q.push_back(cyc);
    end
    if (|done) last_done_cyc <= cyc;
    if ((|gnt) && (|done)) overlap_cnt <= overlap_cnt + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i])  gnt_cnt[i]  <= gnt_cnt[i] + 1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    Rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    Rst = 1'b0;
  endtask

  task automatic wait_gnt(input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt[r]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!arb_busy && !tx_busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (gnt !== 2'b00) $display("FAIL reset_gnt got %b exp 00", gnt); else passed++;
    total++; if (done !== 2'b00) $display("FAIL reset_done got %b exp 00", done); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b exp 0", tx_start); else passed++;
    total++; if (arb_busy !== 1'b0) $display("FAIL reset_arb_busy got %b exp 0", arb_busy); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else passed++;
    Rst = 1'b0;
  endtask

  task automatic test_single();
    int b0, g0, d0, rc;
    bit ok;
    logic [31:0] got;
    b0 = byte_q.size(); g0 = gnt_cnt[0]; d0 = done_cnt[0];
    @(negedge clk);
    req_word[31:0] = 32'hDEADBEEF; req_len[1:0] = 2'd3; req[0] = 1'b1; rc = cyc;
    wait_gnt(0, 10, ok);
    req[0] = 1'b0;
    total++; if (!ok) $display("FAIL single_gnt_timeout got none exp gnt[0]"); else passed++;
    wait_idle(500, ok);
    total++; if (!ok) $display("FAIL single_idle_timeout got busy exp idle"); else passed++;
    total++; if (byte_q.size() - b0 !== 4) $display("FAIL single_count got %0d exp 4", byte_q.size() - b0); else passed++;
    got = {byte_q[b0+3], byte_q[b0+2], byte_q[b0+1], byte_q[b0]};
    total++; if (got !== 32'hDEADBEEF) $display("FAIL single_bytes got %h exp deadbeef", got); else passed++;
    total++; if (start_q[b0] - rc !== 2) $display("FAIL single_latency got %0d exp 2", start_q[b0] - rc); else passed++;
    total++; if (start_q[b0+1] - start_q[b0] !== 13) $display("FAIL single_spacing got %0d exp 13", start_q[b0+1] - start_q[b0]); else passed++;
    total++; if (gnt_cnt[0] - g0 !== 1) $display("FAIL single_gnt_count got %0d exp 1", gnt_cnt[0] - g0); else passed++;
    total++; if (done_cnt[0] - d0 !== 1) $display("FAIL single_done_count got %0d exp 1", done_cnt[0] - d0); else passed++;
  endtask

  task automatic test_contention();
    int b0, ng;
    bit ok;
    logic [31:0] got, exp_seq;
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_seq = 32'h11111111;
`else
    exp_seq = 32'h11221122;
`endif
    do_reset();
    b0 = byte_q.size();
    req_word[31:0] = 32'h00000011; req_word[63:32] = 32'h00000022; req_len = 4'b0000;
    req = 2'b11;
    ng = 0;
    for (int i = 0; i < 400 && ng < 4; i++) begin
      @(negedge clk);
      if (|gnt) ng++;
    end
    req = 2'b00;
    total++; if (ng !== 4) $display("FAIL contention_gnts got %0d exp 4", ng); else passed++;
    wait_idle(500, ok);
    total++; if (byte_q.size() - b0 !== 4) $display("FAIL contention_count got %0d exp 4", byte_q.size() - b0); else passed++;
    got = {byte_q[b0], byte_q[b0+1], byte_q[b0+2], byte_q[b0+3]};
    total++; if (got !== exp_seq) $display("FAIL contention_order got %h exp %h", got, exp_seq); else passed++;
  endtask

  task automatic test_short();
    int b0, d0;
    bit ok;
    b0 = byte_q.size(); d0 = done_cnt[0];
    @(negedge clk);
    req_word[31:0] = 32'hAABBCCDD; req_len[1:0] = 2'd1; req[0] = 1'b1;
    wait_gnt(0, 10, ok);
    req[0] = 1'b0;
    wait_idle(500, ok);
    total++; if (byte_q.size() - b0 !== 2) $display("FAIL short_count got %0d exp 2", byte_q.size() - b0); else passed++;
    total++; if ({byte_q[b0], byte_q[b0+1]} !== 16'hDDCC) $display("FAIL short_bytes got %h%h exp ddcc", byte_q[b0], byte_q[b0+1]); else passed++;
    total++; if (done_cnt[0] - d0 !== 1) $display("FAIL short_done_count got %0d exp 1", done_cnt[0] - d0); else passed++;
    total++; if (last_done_cyc - start_q[b0+1] !== 12) $display("FAIL short_done_timing got %0d exp 12", last_done_cyc - start_q[b0+1]); else passed++;
  endtask

  task automatic test_ack_timeout();
    int b0, d0;
    bit ok;
    b0 = byte_q.size(); d0 = done_cnt[0];
    skip_idx = start_cnt;
    @(negedge clk);
    req_word[31:0] = 32'h00003C5A; req_len[1:0] = 2'd1; req[0] = 1'b1;
    wait_gnt(0, 10, ok);
    req[0] = 1'b0;
    wait_idle(500, ok);
    total++; if (byte_q.size() - b0 !== 3) $display("FAIL timeout_starts got %0d exp 3", byte_q.size() - b0); else passed++;
    total++; if (start_q[b0+1] - start_q[b0] !== 17) $display("FAIL timeout_retry_cycle got %0d exp 17", start_q[b0+1] - start_q[b0]); else passed++;
    total++; if ({byte_q[b0], byte_q[b0+1], byte_q[b0+2]} !== 24'h5A5A3C) $display("FAIL timeout_bytes got %h%h%h exp 5a5a3c", byte_q[b0], byte_q[b0+1], byte_q[b0+2]); else passed++;
    total++; if (done_cnt[0] - d0 !== 1) $display("FAIL timeout_done_count got %0d exp 1", done_cnt[0] - d0); else passed++;
  endtask

  task automatic test_reset_mid();
    int b0, d0, g1, d1, ns;
    bit ok;
    b0 = byte_q.size(); d0 = done_cnt[0];
    @(negedge clk);
    req_word[31:0] = 32'h44332211; req_len[1:0] = 2'd3; req[0] = 1'b1;
    wait_gnt(0, 10, ok);
    req[0] = 1'b0;
    ns = 0;
    for (int i = 0; i < 100 && ns < 2; i++) begin
      @(negedge clk);
      if (tx_start) ns++;
    end
    total++; if (ns !== 2) $display("FAIL resetmid_reach_byte1 got %0d exp 2", ns); else passed++;
    repeat (3) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    total++; if ({gnt, done, tx_start, arb_busy} !== 6'b000000) $display("FAIL resetmid_ctrl got %b exp 000000", {gnt, done, tx_start, arb_busy}); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL resetmid_tx_data got %h exp 00", tx_data); else passed++;
    Rst = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (done_cnt[0] - d0 !== 0) $display("FAIL resetmid_no_done got %0d exp 0", done_cnt[0] - d0); else passed++;
    total++; if (byte_q.size() - b0 !== 2) $display("FAIL resetmid_bytes got %0d exp 2", byte_q.size() - b0); else passed++;
    b0 = byte_q.size(); g1 = gnt_cnt[1]; d1 = done_cnt[1];
    req_word[63:32] = 32'h00000077; req_len[3:2] = 2'd0; req[1] = 1'b1;
    wait_gnt(1, 10, ok);
    req[1] = 1'b0;
    total++; if (!ok) $display("FAIL resetmid_new_gnt got none exp gnt[1]"); else passed++;
    wait_idle(500, ok);
    total++; if (byte_q.size() - b0 !== 1 || byte_q[b0] !== 8'h77) $display("FAIL resetmid_new_byte got %0d bytes first %h exp 1 byte 77", byte_q.size() - b0, byte_q[b0]); else passed++;
    total++; if (done_cnt[1] - d1 !== 1 || gnt_cnt[1] - g1 !== 1) $display("FAIL resetmid_new_handshake got gnt %0d done %0d exp 1 1", gnt_cnt[1] - g1, done_cnt[1] - d1); else passed++;
  endtask

  task automatic test_withdraw();
    int b0, d0, g1;
    bit ok;
    b0 = byte_q.size(); d0 = done_cnt[0]; g1 = gnt_cnt[1];
    @(negedge clk);
    req_word[31:0] = 32'h000000A5; req_len[1:0] = 2'd0; req[0] = 1'b1;
    wait_gnt(0, 10, ok);
    req[0] = 1'b0;
    @(negedge clk);
    req_word[63:32] = 32'h00000099; req_len[3:2] = 2'd0; req[1] = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_idle(500, ok);
    repeat (3) @(negedge clk);
    total++; if (gnt_cnt[1] - g1 !== 0) $display("FAIL withdraw_gnt1 got %0d exp 0", gnt_cnt[1] - g1); else passed++;
    total++; if (done_cnt[0] - d0 !== 1) $display("FAIL withdraw_done0 got %0d exp 1", done_cnt[0] - d0); else passed++;
    total++; if (byte_q.size() - b0 !== 1 || byte_q[b0] !== 8'hA5) $display("FAIL withdraw_bytes got %0d bytes first %h exp 1 byte a5", byte_q.size() - b0, byte_q[b0]); else passed++;
    total++; if (arb_busy !== 1'b0) $display("FAIL withdraw_idle got %b exp 0", arb_busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_short();
    test_ack_timeout();
    test_reset_mid();
    test_withdraw();
    total++; if (overlap_cnt !== 0) $display("FAIL gnt_done_overlap got %0d exp 0", overlap_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "global timeout");
  end

endmodule
